// File: rtl/pon_tx_queue_scheduler.sv
// ---------------------------------------------------------------------------
// pon_tx_queue_scheduler
//
// Round-robin scheduler that shares the single GT Tx lane of the PON transmit
// path between NUM_Q per-class AXIS queue FIFOs. One eligible queue is granted
// per arbitration. Its FIFO read enable is driven for exactly one frame (up to
// and including the TLAST word). The lane then stays idle for a drain window,
// which lets the downstream pipeline flush, followed by a guard gap.
//
// Ports:
//   clk            single clock for all logic
//   rst_n          synchronous active-low reset
//   q_level        per-queue fill level, queue i at [i*LEVEL_W +: LEVEL_W]
//   q_frame_ready  queue i holds at least one complete frame
//   q_rd_tlast     head word of queue i carries TLAST
//   GT_Tx_active   GT transmitter is up and accepting data
//   tx_ready       downstream framer accepts a word this cycle
//   q_rd_en        one-hot FIFO read enable (combinational)
//   grant_q        index of the granted queue (registered)
//   burst_active   high while reading a frame or draining after it
//   burst_done     one-cycle pulse in the first guard cycle
// ---------------------------------------------------------------------------
module pon_tx_queue_scheduler #(
  parameter int NUM_Q        = 4,
  parameter int LEVEL_W      = 10,
  parameter int MIN_LEVEL    = 16,
  parameter int DRAIN_CYCLES = 15,
  parameter int GUARD_CYCLES = 4,
  localparam int QW          = $clog2(NUM_Q)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_Q*LEVEL_W-1:0]   q_level,
  input  logic [NUM_Q-1:0]           q_frame_ready,
  input  logic [NUM_Q-1:0]           q_rd_tlast,
  input  logic                       GT_Tx_active,
  input  logic                       tx_ready,
  output logic [NUM_Q-1:0]           q_rd_en,
  output logic [QW-1:0]              grant_q,
  output logic                       burst_active,
  output logic                       burst_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  // Counters stop at PARAM-1 and move on, so they never wrap.
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

  logic [1:0]          state;
  logic [QW-1:0]       rr_ptr;
  logic [7:0]          drain_cnt;
  logic [7:0]          guard_cnt;

  logic [LEVEL_W-1:0]  level [NUM_Q];
  logic [NUM_Q-1:0]    elig;
  logic [QW-1:0]       next_grant;
  logic [QW-1:0]       cand;
  logic                any_elig;
  logic                rd_fire;

  // Unpack the fill levels and work out which queues may be served.
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      level[i] = q_level[i*LEVEL_W +: LEVEL_W];
      elig[i]  = GT_Tx_active &
                 (q_frame_ready[i] | (level[i] >= LEVEL_W'(MIN_LEVEL)));
    end
  end

  // Round-robin search starting just after the last-served queue. NUM_Q is a
  // power of two, so the QW-bit sum wraps modulo NUM_Q on its own; k = NUM_Q
  // lands back on rr_ptr, giving the last-served queue the lowest priority.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    next_grant = '0;
    any_elig   = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_Q; k++) begin
      cand = rr_ptr + QW'(k);
      if (!any_elig && elig[cand]) begin
        any_elig   = 1'b1;
        next_grant = cand;
      end
    end
  end

  // A read only happens when the lane, the framer and the FIFO can all take
  // part; otherwise it is paused rather than aborted. Gating with rst_n drops
  // the enable in the very cycle a reset is applied, before the state reloads.
  assign rd_fire = rst_n && (state == S_READ) && tx_ready && GT_Tx_active &&
                   (level[grant_q] != '0);

  always_comb begin
    q_rd_en          = '0;
    q_rd_en[grant_q] = rd_fire;
  end

  assign burst_active = (state == S_READ) || (state == S_DRAIN);

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    if (!rst_n) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      rr_ptr     <= QW'(NUM_Q - 1);
      drain_cnt  <= '0;
      guard_cnt  <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            grant_q <= next_grant;
            rr_ptr  <= next_grant;
            state   <= S_READ;
          end
        end
        S_READ: begin
          if (rd_fire && q_rd_tlast[grant_q]) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Counting continues even if GT_Tx_active drops.
          if (drain_cnt == DRAIN_LAST) begin
            guard_cnt  <= '0;
            burst_done <= 1'b1;
            state      <= S_GUARD;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        S_GUARD: begin
          if (guard_cnt == GUARD_LAST) begin
            state <= S_IDLE;
          end else begin
            guard_cnt <= guard_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pon_tx_queue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pon_tx_queue_scheduler
//
// Directed bench for pon_tx_queue_scheduler. The queue FIFOs are modelled as
// queues of TLAST flags that pop whenever the DUT asserts the matching read
// enable. A timeline model (reading, or N cycles after the last read) gives
// the expected outputs each cycle; literal checks pin the model on grant order,
// read counts and burst spacing.
// ---------------------------------------------------------------------------
module tb_pon_tx_queue_scheduler;

  localparam int NUM_Q     = 4;
  localparam int LEVEL_W   = 10;
  localparam int MIN_LEVEL = 16;
  localparam int D         = 15;
  localparam int G         = 4;
  localparam int QW        = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_Q*LEVEL_W-1:0] q_level;
  logic [NUM_Q-1:0]         q_frame_ready;
  logic [NUM_Q-1:0]         q_rd_tlast;
  logic                     GT_Tx_active;
  logic                     tx_ready;
  logic [NUM_Q-1:0]         q_rd_en;
  logic [QW-1:0]            grant_q;
  logic                     burst_active;
  logic                     burst_done;

  pon_tx_queue_scheduler #(
    .NUM_Q(NUM_Q), .LEVEL_W(LEVEL_W), .MIN_LEVEL(MIN_LEVEL),
    .DRAIN_CYCLES(D), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .q_level(q_level),
    .q_frame_ready(q_frame_ready), .q_rd_tlast(q_rd_tlast),
    .GT_Tx_active(GT_Tx_active), .tx_ready(tx_ready),
    .q_rd_en(q_rd_en), .grant_q(grant_q),
    .burst_active(burst_active), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- queue FIFO environment ----------------
  bit fifo [NUM_Q][$];
  logic [NUM_Q-1:0] last_snap;

  function automatic void refresh();
    for (int i = 0; i < NUM_Q; i++) begin
      q_level[i*LEVEL_W +: LEVEL_W] = LEVEL_W'(fifo[i].size());
      q_frame_ready[i] = 1'b0;
      for (int j = 0; j < fifo[i].size(); j++)
        if (fifo[i][j]) q_frame_ready[i] = 1'b1;
      q_rd_tlast[i] = (fifo[i].size() != 0) ? fifo[i][0] : 1'b0;
    end
  endfunction

  task automatic push(input int q, input int n, input bit last);
    for (int j = 0; j < n; j++) fifo[q].push_back(last && (j == n - 1));
  endtask

  // Called at a falling edge with the cycle's inputs already set.
  task automatic tick();
    refresh();
    #3;
    last_snap = q_rd_en;
    @(negedge clk);
    for (int i = 0; i < NUM_Q; i++)
      if (last_snap[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int at(input int q[$], input int idx);
    return (idx >= 0 && idx < q.size()) ? q[idx] : -1;
  endfunction

  // ---------------- model, compare and burst log ----------------
  bit m_valid   = 1'b0;
  bit m_reading = 1'b0;
  int m_post    = 0;    // cycles since the last read of a burst, 0 = idle
  int m_grant   = 0;
  int m_last    = NUM_Q - 1;

  int grant_log[$];
  int done_log[$];
  int reads_log[$];
  int first_log[$];
  int last_log[$];
  int rd_cnt_q [NUM_Q];
  int bad_rd    = 0;
  int cur_reads = 0;
  int first_rd  = 0;
  int last_rd   = 0;
  bit prev_ba   = 1'b0;

  always begin
    logic [NUM_Q-1:0] exp_rd;
    bit               elig [NUM_Q];
    int               lv   [NUM_Q];
    bit               rd;
    bit               found;
    @(negedge clk);
    #2;
    cyc++;
    for (int i = 0; i < NUM_Q; i++) begin
      lv[i]   = int'(q_level[i*LEVEL_W +: LEVEL_W]);
      elig[i] = GT_Tx_active && (q_frame_ready[i] || lv[i] >= MIN_LEVEL);
    end
    rd = m_reading && rst_n && tx_ready && GT_Tx_active && (lv[m_grant] != 0);
    if (m_valid) begin
      exp_rd = '0;
      if (rd) exp_rd[m_grant] = 1'b1;
      check("q_rd_en", 32'(q_rd_en), 32'(exp_rd));
      check("grant_q", 32'(grant_q), m_grant);
      check("burst_active", 32'(burst_active),
            32'(m_reading || (m_post >= 1 && m_post <= D)));
      check("burst_done", 32'(burst_done), 32'(m_post == D + 1));
    end

    if (rst_n) begin
      if (burst_active && !prev_ba) begin
        grant_log.push_back(int'(grant_q));
        cur_reads = 0;
      end
      for (int i = 0; i < NUM_Q; i++) begin
        if (q_rd_en[i]) begin
          rd_cnt_q[i]++;
          cur_reads++;
          if (cur_reads == 1) first_rd = cyc;
          last_rd = cyc;
          if (!tx_ready || !GT_Tx_active) bad_rd++;
        end
      end
      if (burst_done) begin
        done_log.push_back(cyc);
        reads_log.push_back(cur_reads);
        first_log.push_back(first_rd);
        last_log.push_back(last_rd);
      end
    end
    prev_ba = burst_active;

    if (!rst_n) begin
      m_valid   = 1'b1;
      m_reading = 1'b0;
      m_post    = 0;
      m_grant   = 0;
      m_last    = NUM_Q - 1;
    end else if (m_valid) begin
      if (m_reading) begin
        if (rd && q_rd_tlast[m_grant]) begin
          m_reading = 1'b0;
          m_post    = 1;
        end
      end else if (m_post > 0) begin
        m_post = (m_post == D + G) ? 0 : m_post + 1;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NUM_Q; k++) begin
          if (!found && elig[(m_last + k) % NUM_Q]) begin
            found     = 1'b1;
            m_grant   = (m_last + k) % NUM_Q;
            m_last    = m_grant;
            m_reading = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g, b, base, n;
    for (int i = 0; i < NUM_Q; i++) rd_cnt_q[i] = 0;
    rst_n = 1'b0; GT_Tx_active = 1'b1; tx_ready = 1'b1;
    refresh();
    @(negedge clk);

    // Reset and idle
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    check("idle_reads", rd_cnt_q[0] + rd_cnt_q[1] + rd_cnt_q[2] + rd_cnt_q[3], 0);
    check("idle_grants", grant_log.size(), 0);
    check("idle_grant_q", 32'(grant_q), 0);

    // GT down in IDLE blocks arbitration; then round-robin over all queues
    GT_Tx_active = 1'b0;
    push(0, 4, 1); push(0, 4, 1); push(1, 4, 1); push(2, 4, 1); push(3, 4, 1);
    ticks(5);
    check("gt_low_no_grant", grant_log.size(), 0);
    check("gt_low_idle", 32'(burst_active), 0);
    GT_Tx_active = 1'b1;
    ticks(130);
    check("rr_0", at(grant_log, 0), 0);
    check("rr_1", at(grant_log, 1), 1);
    check("rr_2", at(grant_log, 2), 2);
    check("rr_3", at(grant_log, 3), 3);
    check("rr_4", at(grant_log, 4), 0);
    check("rr_reads", at(reads_log, 2), 4);

    // Serve q1, then q1 and q3 together: q3 must win
    g = grant_log.size();
    push(1, 4, 1);
    ticks(30);
    push(1, 4, 1); push(3, 4, 1);
    ticks(60);
    check("rr_q1", at(grant_log, g), 1);
    check("rr_q3_after_q1", at(grant_log, g + 1), 3);
    check("rr_q1_last", at(grant_log, g + 2), 1);

    // Threshold eligibility, 20-word frame, then a second frame at min spacing
    g = grant_log.size(); b = done_log.size(); base = rd_cnt_q[2];
    push(2, 16, 0);
    tick();
    push(2, 4, 1); push(2, 4, 1);
    ticks(80);
    check("thr_grant", at(grant_log, g), 2);
    check("thr_reads", at(reads_log, b), 20);
    check("thr_contiguous", at(last_log, b) - at(first_log, b), 19);
    check("thr_done_offset", at(done_log, b) - at(last_log, b), 16);
    check("thr_spacing", at(first_log, b + 1) - at(last_log, b), 21);
    check("thr_total_q2", rd_cnt_q[2] - base, 24);

    // Backpressure and GT stall on a 10-word frame
    g = grant_log.size(); b = done_log.size(); base = bad_rd;
    push(0, 10, 1);
    for (int i = 0; i < 40; i++) begin
      tx_ready     = (i % 2 == 0);
      GT_Tx_active = !(i >= 8 && i < 13);
      tick();
      if (i >= 8 && i < 13) check("stall_busy", 32'(burst_active), 1);
    end
    tx_ready = 1'b1; GT_Tx_active = 1'b1;
    ticks(30);
    check("bp_grant", at(grant_log, g), 0);
    check("bp_reads", at(reads_log, b), 10);
    check("bp_no_bad_reads", bad_rd - base, 0);

    // Underflow guard; GT down during the drain must not stretch it
    g = grant_log.size(); b = done_log.size();
    push(3, 16, 0);
    n = 0;
    while (fifo[3].size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("uf_drain_budget", 32'(n < 100), 1);
    base = rd_cnt_q[3];
    ticks(3);
    check("uf_no_read", rd_cnt_q[3] - base, 0);
    check("uf_still_busy", 32'(burst_active), 1);
    push(3, 1, 1);
    ticks(2);
    GT_Tx_active = 1'b0;
    ticks(10);
    GT_Tx_active = 1'b1;
    ticks(25);
    check("uf_grant", at(grant_log, g), 3);
    check("uf_reads", at(reads_log, b), 17);
    check("uf_done_offset", at(done_log, b) - at(last_log, b), 16);

    // Reset on word 5 of a 12-word frame; rr pointer must restart at q0
    push(0, 12, 1);
    tick();
    push(1, 4, 1);
    base = rd_cnt_q[0];
    n = 0;
    while (rd_cnt_q[0] - base < 4 && n < 50) begin
      tick();
      n++;
    end
    check("rst_reach_word5", rd_cnt_q[0] - base, 4);
    rst_n = 1'b0;
    tick();
    check("rst_rd_en_drop", 32'(last_snap), 0);
    tick();
    check("rst_idle", 32'(burst_active), 0);
    check("rst_grant_q", 32'(grant_q), 0);
    g = grant_log.size();
    rst_n = 1'b1;
    ticks(70);
    check("rst_q0_first", at(grant_log, g), 0);
    check("rst_q1_next", at(grant_log, g + 1), 1);
    check("rst_total_q0", rd_cnt_q[0] - base, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
